// File: rtl/clock_display_driver_if.sv
// Signal bundle between the ClockModule side (master) and the display driver (slave).
// Valid/ready is not used: inputs are level signals sampled on i_clk, outputs are registered levels.
interface clock_display_driver_if;
    logic       i_ms_pulse;
    logic [4:0] i_hr;
    logic [5:0] i_min;
    logic [5:0] i_sec;
    logic       i_set;
    logic [1:0] i_field;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [5:0] o_an;
    logic       o_busy;
    logic [1:0] o_dbg_state;

    modport master (
        output i_ms_pulse, i_hr, i_min, i_sec, i_set, i_field,
        input  o_seg, o_dp, o_an, o_busy, o_dbg_state
    );

    modport slave (
        input  i_ms_pulse, i_hr, i_min, i_sec, i_set, i_field,
        output o_seg, o_dp, o_an, o_busy, o_dbg_state
    );
endinterface

// File: rtl/clock_display_driver.sv
// 6-digit multiplexed common-anode 7-segment driver with sequential double-dabble BCD conversion.
// Optional macro CLOCK_DISP_LEADING_BLANK_EN blanks a zero hours-tens digit.
module clock_display_driver #(
    parameter int SCAN_TICKS  = 1,
    parameter int BLINK_TICKS = 250
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    clock_display_driver_if.slave  io_bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_load;
    logic            w_shift;
    logic            w_commit;
    logic            w_busy;

    logic            r_ms_q;
    logic            r_ms_qq;
    logic            w_tick;

    logic [4:0]      r_step;
    logic [13:0]     r_work_sec;
    logic [13:0]     r_work_min;
    logic [13:0]     r_work_hr;
    logic [2:0]      r_snap_bad;
    logic [5:0][3:0] r_disp;
    logic [2:0]      r_disp_bad;

    logic            r_started;
    logic [2:0]      r_dig;
    logic [7:0]      r_scan_cnt;
    logic [9:0]      r_blink_cnt;
    logic            r_phase_off;
    logic            r_set_q;
    logic [1:0]      r_field_q;
    logic            w_restart;

    logic [1:0]      w_pair;
    logic [3:0]      w_nibble;
    logic            w_bad;
    logic            w_blank;
    logic [6:0]      w_seg_nxt;
    logic            w_dp_nxt;
    logic [5:0]      w_an_nxt;

    logic [6:0]      r_seg;
    logic            r_dp;
    logic [5:0]      r_an;

    // One double-dabble iteration on {bcd_tens, bcd_ones, bin[5:0]}: adjust, then shift.
    function automatic logic [13:0] dd_step(input logic [13:0] w);
        logic [13:0] a;
        a = w;
        if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
        if (a[9:6] >= 4'd5)   a[9:6]   = a[9:6] + 4'd3;
        return {a[12:0], 1'b0};
    endfunction

    function automatic logic [6:0] font7(input logic [3:0] d);
        case (d)
            4'd0:    font7 = 7'b1000000;
            4'd1:    font7 = 7'b1111001;
            4'd2:    font7 = 7'b0100100;
            4'd3:    font7 = 7'b0110000;
            4'd4:    font7 = 7'b0011001;
            4'd5:    font7 = 7'b0010010;
            4'd6:    font7 = 7'b0000010;
            4'd7:    font7 = 7'b1111000;
            4'd8:    font7 = 7'b0000000;
            4'd9:    font7 = 7'b0010000;
            default: font7 = 7'b1111111;
        endcase
    endfunction

    assign w_tick    = r_ms_q & ~r_ms_qq;
    assign w_restart = (io_bus.i_set & ~r_set_q) | (io_bus.i_field != r_field_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ms_q  <= 1'b0;
            r_ms_qq <= 1'b0;
            r_state <= S_IDLE;
        end else begin
            r_ms_q  <= io_bus.i_ms_pulse;
            r_ms_qq <= r_ms_q;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                w_busy  = 1'b1;
                if (r_step == 5'd17) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Steps 0-5 convert sec, 6-11 min, 12-17 hr; range flags are frozen with the snapshot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step     <= 5'd0;
            r_work_sec <= 14'd0;
            r_work_min <= 14'd0;
            r_work_hr  <= 14'd0;
            r_snap_bad <= 3'b000;
            r_disp     <= '0;
            r_disp_bad <= 3'b000;
        end else begin
            if (w_load) begin
                r_step     <= 5'd0;
                r_work_sec <= {8'd0, io_bus.i_sec};
                r_work_min <= {8'd0, io_bus.i_min};
                r_work_hr  <= {8'd0, 1'b0, io_bus.i_hr};
                r_snap_bad <= {(io_bus.i_hr > 5'd23), (io_bus.i_min > 6'd59), (io_bus.i_sec > 6'd59)};
            end
            if (w_shift) begin
                r_step <= r_step + 5'd1;
                if (r_step < 5'd6)       r_work_sec <= dd_step(r_work_sec);
                else if (r_step < 5'd12) r_work_min <= dd_step(r_work_min);
                else                     r_work_hr  <= dd_step(r_work_hr);
            end
            if (w_commit) begin
                r_disp     <= {r_work_hr[13:6], r_work_min[13:6], r_work_sec[13:6]};
                r_disp_bad <= r_snap_bad;
            end
        end
    end

    // The first tick after reset only enables the display on digit 0; later ticks drive the scan.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_started   <= 1'b0;
            r_dig       <= 3'd0;
            r_scan_cnt  <= 8'd0;
            r_blink_cnt <= 10'd0;
            r_phase_off <= 1'b0;
            r_set_q     <= 1'b0;
            r_field_q   <= 2'd0;
        end else begin
            r_set_q   <= io_bus.i_set;
            r_field_q <= io_bus.i_field;
            if (w_tick) begin
                if (!r_started) begin
                    r_started <= 1'b1;
                end else if (r_scan_cnt == 8'(SCAN_TICKS - 1)) begin
                    r_scan_cnt <= 8'd0;
                    r_dig      <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
                end else begin
                    r_scan_cnt <= r_scan_cnt + 8'd1;
                end
            end
            if (w_restart) begin
                r_blink_cnt <= 10'd0;
                r_phase_off <= 1'b0;
            end else if (w_tick) begin
                if (r_blink_cnt == 10'(BLINK_TICKS - 1)) begin
                    r_blink_cnt <= 10'd0;
                    r_phase_off <= ~r_phase_off;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        w_pair   = 2'd2;
        w_nibble = r_disp[5];
        case (r_dig)
            3'd0: begin w_pair = 2'd0; w_nibble = r_disp[0]; end
            3'd1: begin w_pair = 2'd0; w_nibble = r_disp[1]; end
            3'd2: begin w_pair = 2'd1; w_nibble = r_disp[2]; end
            3'd3: begin w_pair = 2'd1; w_nibble = r_disp[3]; end
            3'd4: begin w_pair = 2'd2; w_nibble = r_disp[4]; end
            default: begin w_pair = 2'd2; w_nibble = r_disp[5]; end
        endcase
        w_bad = r_disp_bad[w_pair];
        // A pending restart masks a stale off phase so a newly selected field shows at once.
        w_blank   = io_bus.i_set & (io_bus.i_field == w_pair) & r_phase_off & ~w_restart;
        w_an_nxt  = ~(6'b000001 << r_dig);
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (!w_blank) begin
            w_dp_nxt = ~((r_dig == 3'd4) | (r_dig == 3'd2));
            if (w_bad) w_seg_nxt = 7'b0111111;
            else       w_seg_nxt = font7(w_nibble);
`ifdef CLOCK_DISP_LEADING_BLANK_EN
            if ((r_dig == 3'd5) && (w_nibble == 4'd0) && !w_bad) w_seg_nxt = 7'h7F;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !r_started) begin
            r_an  <= 6'b111111;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign io_bus.o_an        = r_an;
    assign io_bus.o_seg       = r_seg;
    assign io_bus.o_dp        = r_dp;
    assign io_bus.o_busy      = w_busy;
    assign io_bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver: directed scenarios plus random ticks, checked against
// a digit-level model of what the display should show after each scan tick.
module tb_clock_display_driver;
    localparam int SCAN_T  = 1;
    localparam int BLINK_T = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_display_driver_if bus();

    clock_display_driver #(
        .SCAN_TICKS (SCAN_T),
        .BLINK_TICKS(BLINK_T)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;

    // Model state: committed field values, tick counts since reset / since blink restart.
    int m_ticks, m_blink, m_hr, m_min, m_sec, m_field;
    bit m_set;
    int cur_hr, cur_min, cur_sec;
    logic [13:0] exp_q[$];

    always @(negedge clk) if (bus.o_busy === 1'b1) busy_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] digit_font(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {an, seg, dp} for the digit currently scanned.
    function automatic logic [13:0] exp_disp();
        int idx, pair, val, lim, d;
        bit blank;
        logic [5:0] an;
        logic [6:0] seg;
        logic dp;
        if (m_ticks == 0) return {6'h3F, 7'h7F, 1'b1};
        idx   = (m_ticks - 1) % 6;
        pair  = idx / 2;
        val   = (pair == 0) ? m_sec : (pair == 1) ? m_min : m_hr;
        lim   = (pair == 2) ? 23 : 59;
        blank = m_set && (m_field == pair) && (((m_blink / BLINK_T) % 2) == 1);
        an    = ~(6'b000001 << idx);
        if (blank) begin
            seg = 7'h7F;
            dp  = 1'b1;
        end else begin
            dp = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
            if (val > lim) begin
                seg = 7'b0111111;
            end else begin
                d   = (idx % 2 == 1) ? val / 10 : val % 10;
                seg = digit_font(d);
`ifdef CLOCK_DISP_LEADING_BLANK_EN
                if (idx == 5 && d == 0) seg = 7'h7F;
`endif
            end
        end
        return {an, seg, dp};
    endfunction

    task automatic check_display(input string tag);
        logic [13:0] e;
        exp_q.push_back(exp_disp());
        e = exp_q.pop_front();
        check({tag, ".an"},  {26'd0, bus.o_an},  {26'd0, e[13:8]});
        check({tag, ".seg"}, {25'd0, bus.o_seg}, {25'd0, e[7:1]});
        check({tag, ".dp"},  {31'd0, bus.o_dp},  {31'd0, e[0]});
    endtask

    task automatic set_inputs(input int hr, input int mn, input int sc);
        cur_hr = hr; cur_min = mn; cur_sec = sc;
        bus.i_hr  = 5'(hr);
        bus.i_min = 6'(mn);
        bus.i_sec = 6'(sc);
    endtask

    task automatic set_mode(input bit s, input int f);
        if ((s && !m_set) || (f != m_field)) m_blink = 0;
        m_set = s; m_field = f;
        bus.i_set   = s;
        bus.i_field = 2'(f);
    endtask

    task automatic send_pulse(input int width);
        bus.i_ms_pulse = 1'b1;
        repeat (width) @(posedge clk);
        #1 bus.i_ms_pulse = 1'b0;
    endtask

    task automatic apply_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.an",   {26'd0, bus.o_an},   32'h3F);
        check("rst.seg",  {25'd0, bus.o_seg},  32'h7F);
        check("rst.dp",   {31'd0, bus.o_dp},   32'h1);
        check("rst.busy", {31'd0, bus.o_busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ticks = 0; m_blink = 0; m_hr = 0; m_min = 0; m_sec = 0;
    endtask

    // One tick with stable inputs; the conversion completes well inside the wait.
    task automatic do_tick(input int width, input string tag);
        busy_cnt = 0;
        send_pulse(width);
        repeat (26) @(posedge clk);
        m_ticks++; m_blink++;
        m_hr = cur_hr; m_min = cur_min; m_sec = cur_sec;
        @(negedge clk);
        check({tag, ".busy_cycles"}, busy_cnt, 19);
        check_display(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_ms_pulse = 1'b0;
        m_set = 1'b0; m_field = 3;
        set_mode(0, 3);
        set_inputs(0, 0, 0);
        apply_reset();

        // Basic conversion, then the full scan walk over six digits and back to digit 0.
        set_inputs(13, 45, 7);
        for (int i = 0; i < 7; i++) do_tick(1, "walk");

        // In-range maximum, then hr/min out of range with sec unchanged.
        set_inputs(23, 59, 59);
        for (int i = 0; i < 6; i++) do_tick(1 + (i % 3), "max");
        set_inputs(24, 60, 59);
        for (int i = 0; i < 6; i++) do_tick(1, "range");

        // Blink on minutes; switch to hours while the min ones digit is blanked.
        apply_reset();
        set_inputs(12, 34, 56);
        set_mode(1, 1);
        for (int i = 0; i < 3; i++) do_tick(1, "blink_min");
        set_mode(1, 2);
        @(posedge clk);
        @(negedge clk);
        check_display("field_switch");
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) do_tick(1, "blink_hr");
        set_mode(0, 3);

        // Second tick during conversion is dropped; only the first snapshot commits.
        set_inputs(10, 20, 30);
        busy_cnt = 0;
        send_pulse(1);
        repeat (5) @(posedge clk);
        #1 set_inputs(22, 33, 44);
        send_pulse(1);
        repeat (30) @(posedge clk);
        m_ticks += 2; m_blink += 2;
        m_hr = 10; m_min = 20; m_sec = 30;
        @(negedge clk);
        check("drop.busy_cycles", busy_cnt, 19);
        check_display("drop");
        @(posedge clk);
        #1;
        do_tick(1, "after_drop");

        // Reset at conversion cycle 10: outputs return to reset and nothing commits.
        set_inputs(1, 2, 7);
        send_pulse(1);
        repeat (10) @(posedge clk);
        #1;
        check("abort.busy_mid", {31'd0, bus.o_busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.an",   {26'd0, bus.o_an},   32'h3F);
        check("abort.seg",  {25'd0, bus.o_seg},  32'h7F);
        check("abort.dp",   {31'd0, bus.o_dp},   32'h1);
        check("abort.busy", {31'd0, bus.o_busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ticks = 0; m_blink = 0; m_hr = 0; m_min = 0; m_sec = 0;
        send_pulse(1);
        repeat (3) @(posedge clk);
        m_ticks = 1; m_blink = 1;
        @(negedge clk);
        check("abort.busy_new", {31'd0, bus.o_busy}, 32'h1);
        check_display("abort.cleared");
        repeat (25) @(posedge clk);
        m_hr = 1; m_min = 2; m_sec = 7;
        @(negedge clk);
        check_display("abort.recommit");
        @(posedge clk);
        #1;

        // Single-digit hour: hours-tens zero handling.
        set_inputs(5, 8, 9);
        for (int i = 0; i < 6; i++) do_tick(1, "hr5");

        // Random values including out-of-range codes, random pulse widths and blink settings.
        for (int i = 0; i < 30; i++) begin
            set_inputs($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) set_mode(1'($urandom_range(0, 1)), $urandom_range(0, 3));
            do_tick($urandom_range(1, 4), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
